// File: rtl/dl_loader_pkg.sv
// dl_loader_pkg
//   Shared types and helpers for the download/erase engine.
//   - dl_state_t : engine state (IDLE, LOAD, ERASE)
//   - table_base : picks a per-index base address out of a flattened table
package dl_loader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    ERASE = 2'd2
  } dl_state_t;

  // Upper bounds for the generic table lookup; callers zero-extend into these.
  localparam int ADDR_MAX = 64;
  localparam int TBL_MAX  = 2048;

  // Entry i of the table occupies bits [i*aw +: aw]. An index past the end
  // of the table selects the supplied default base.
  function automatic logic [ADDR_MAX-1:0] table_base(
    input logic [TBL_MAX-1:0]  tbl,
    input int                  num,
    input int                  aw,
    input int                  index,
    input logic [ADDR_MAX-1:0] dflt
  );
    logic [ADDR_MAX-1:0] base;
    base = '0;
    if (index >= num) begin
      base = dflt;
    end else begin
      for (int b = 0; b < ADDR_MAX; b++) begin
        if (b < aw) base[b] = tbl[index*aw + b];
      end
    end
    return base;
  endfunction

endpackage

// File: rtl/dl_erase_pacer.sv
// dl_erase_pacer
//   Free-running DIV_W-bit counter that paces erase writes. tick is high
//   while the count is zero, so one tick occurs every 2^DIV_W clocks.
// Ports:
//   clk     in  core clock
//   reset_n in  asynchronous active-low reset
//   clear   in  hold the count at zero (next cycle ticks)
//   tick    out high when the count is zero
module dl_erase_pacer #(
  parameter int DIV_W = 5
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  output logic tick
);

  logic [DIV_W-1:0] count;

  // Counter wraps naturally at 2^DIV_W; clear restarts it at zero.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else begin
      count <= count + DIV_W'(1);
    end
  end

  assign tick = (count == '0);

endmodule

// File: rtl/dl_loader.sv
// dl_loader
//   Core-side file download / erase engine. Turns a byte stream from the SPI
//   file-transfer decoder into single-cycle RAM write strobes at per-index
//   base addresses, optionally erases the tail of the last aligned block,
//   and performs a full-range erase on a force_erase rising edge.
// Ports:
//   clk, reset_n       core clock, asynchronous active-low reset
//   dl_index           menu index, sampled on dl_start
//   dl_start/dl_end    one-cycle pulses framing a download
//   dl_valid, dl_byte  one-cycle byte strobe and data
//   force_erase        level; rising edge requests a full erase
//   wr, addr, dout     write strobe, address, data (addr/dout hold when idle)
//   downloading        high while loading or erasing
//   erasing            high during the erase phase
//   dl_sum, dl_len     byte sum / byte count of the load (only with
//                      DL_LOADER_CHECKSUM_EN defined)
// Optional feature macro: DL_LOADER_CHECKSUM_EN
module dl_loader
  import dl_loader_pkg::*;
#(
  parameter int                    AW           = 25,
  parameter int                    IDX_W        = 5,
  parameter int                    NUM_IDX      = 4,
  parameter logic [NUM_IDX*AW-1:0] BASE_TABLE   = {25'h100000, 25'h010000, 25'h000100, 25'h080000},
  parameter logic [AW-1:0]         DEFAULT_BASE = '0,
  parameter int                    ERASE_INDEX  = 1,
  parameter logic [AW-1:0]         ERASE_MASK   = 25'h0000FF,
  parameter logic [AW-1:0]         FORCE_END    = 25'h4FFFF,
  parameter logic [7:0]            FILL         = 8'h00,
  parameter int                    DIV_W        = 5
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [IDX_W-1:0] dl_index,
  input  logic             dl_start,
  input  logic             dl_end,
  input  logic             dl_valid,
  input  logic [7:0]       dl_byte,
  input  logic             force_erase,
  output logic             wr,
  output logic [AW-1:0]    addr,
  output logic [7:0]       dout,
  output logic             downloading,
  output logic             erasing
`ifdef DL_LOADER_CHECKSUM_EN
  ,
  output logic [15:0]      dl_sum,
  output logic [AW-1:0]    dl_len
`endif
);

  dl_state_t        state;
  logic [AW-1:0]    waddr;
  logic [AW-1:0]    erase_addr;
  logic [AW-1:0]    end_addr;
  logic [IDX_W-1:0] idx;
  logic             force_prev;
  logic             force_rise;
  logic             pacer_clear;
  logic             pacer_tick;
  logic [AW-1:0]    start_base;
  logic [AW-1:0]    end_waddr;

  assign start_base = AW'(table_base(TBL_MAX'(BASE_TABLE), NUM_IDX, AW,
                                     int'(dl_index), ADDR_MAX'(DEFAULT_BASE)));
  assign force_rise = force_erase & ~force_prev;

  // Pacer sits at zero outside ERASE, so the first erase write lands one
  // clock after ERASE is entered; a forced erase restarts it from zero.
  assign pacer_clear = force_rise | (state != ERASE);

  // A byte accepted together with dl_end is written first, so the tail
  // decision must look at the post-increment address.
  assign end_waddr = dl_valid ? waddr + AW'(1) : waddr;

  assign downloading = (state != IDLE);
  assign erasing     = (state == ERASE);

  dl_erase_pacer #(
    .DIV_W (DIV_W)
  ) u_pacer (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (pacer_clear),
    .tick    (pacer_tick)
  );

  // Main engine: force edge beats dl_start beats dl_end beats dl_valid.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      waddr      <= '0;
      erase_addr <= '0;
      end_addr   <= '0;
      idx        <= '0;
      force_prev <= 1'b0;
      wr         <= 1'b0;
      addr       <= '0;
      dout       <= '0;
`ifdef DL_LOADER_CHECKSUM_EN
      dl_sum     <= '0;
      dl_len     <= '0;
`endif
    end else begin
      force_prev <= force_erase;
      wr         <= 1'b0;
      if (force_rise) begin
        erase_addr <= '0;
        end_addr   <= FORCE_END;
        state      <= ERASE;
      end else if (dl_start) begin
        waddr <= start_base;
        idx   <= dl_index;
        state <= LOAD;
`ifdef DL_LOADER_CHECKSUM_EN
        dl_sum <= '0;
        dl_len <= '0;
`endif
      end else begin
        case (state)
          LOAD: begin
            if (dl_valid) begin
              wr    <= 1'b1;
              addr  <= waddr;
              dout  <= dl_byte;
              waddr <= waddr + AW'(1);
`ifdef DL_LOADER_CHECKSUM_EN
              dl_sum <= dl_sum + 16'(dl_byte);
              dl_len <= dl_len + AW'(1);
`endif
            end
            if (dl_end) begin
              if ((int'(idx) == ERASE_INDEX) && ((end_waddr & ERASE_MASK) != '0)) begin
                erase_addr <= end_waddr;
                end_addr   <= end_waddr | ERASE_MASK;
                state      <= ERASE;
              end else begin
                state <= IDLE;
              end
            end
          end
          ERASE: begin
            if (pacer_tick) begin
              wr   <= 1'b1;
              addr <= erase_addr;
              dout <= FILL;
              if (erase_addr == end_addr) begin
                state <= IDLE;
              end else begin
                erase_addr <= erase_addr + AW'(1);
              end
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dl_loader.sv
// tb_dl_loader
//   Self-checking bench for dl_loader: a table of single-byte downloads per
//   index, hand-written multi-cycle sequences (tail erase, aligned end,
//   combined valid/end, forced erase, reset during erase) and a randomized
//   download run checked against a write-list model built from the rules.
//   Build with DL_LOADER_CHECKSUM_EN defined to also check dl_sum/dl_len.
module tb_dl_loader;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [4:0]  dl_index;
  logic        dl_start, dl_end, dl_valid;
  logic [7:0]  dl_byte;
  logic        force_erase;
  logic        wr;
  logic [24:0] addr;
  logic [7:0]  dout;
  logic        downloading, erasing;
`ifdef DL_LOADER_CHECKSUM_EN
  logic [15:0] dl_sum;
  logic [24:0] dl_len;
`endif

  always #5 clk = ~clk;

  dl_loader dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .dl_index    (dl_index),
    .dl_start    (dl_start),
    .dl_end      (dl_end),
    .dl_valid    (dl_valid),
    .dl_byte     (dl_byte),
    .force_erase (force_erase),
    .wr          (wr),
    .addr        (addr),
    .dout        (dout),
    .downloading (downloading),
    .erasing     (erasing)
`ifdef DL_LOADER_CHECKSUM_EN
    ,
    .dl_sum      (dl_sum),
    .dl_len      (dl_len)
`endif
  );

  int total = 0;
  int bad   = 0;
  int unsigned cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int unsigned cyc;
    logic [24:0] a;
    logic [7:0]  d;
  } wr_t;

  typedef struct {
    logic [4:0]  index;
    logic [7:0]  data;
    logic [24:0] exp_addr;
    logic        exp_erase;
  } vec_t;

  wr_t seen[$];
  wr_t expq[$];

  function automatic wr_t mk(input int unsigned c, input logic [24:0] a, input logic [7:0] d);
    wr_t w;
    w.cyc = c;
    w.a   = a;
    w.d   = d;
    return w;
  endfunction

  // Table bases written out independently of the RTL's flattened vector.
  function automatic logic [24:0] model_base(input int idx);
    case (idx)
      0:       return 25'h080000;
      1:       return 25'h000100;
      2:       return 25'h010000;
      3:       return 25'h100000;
      default: return 25'h000000;
    endcase
  endfunction

  // Record every write strobe with the cycle it appeared in.
  always @(negedge clk) begin
    if (wr === 1'b1) seen.push_back(mk(cyc, addr, dout));
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s: got=%0h expected=%0h", name, got, want);
    end
  endtask

  task automatic applyStimulus(input logic start, input logic [4:0] idx, input logic valid,
                               input logic [7:0] b, input logic endp, output int unsigned edge_no);
    dl_start = start;
    dl_index = idx;
    dl_valid = valid;
    dl_byte  = b;
    dl_end   = endp;
    @(posedge clk);
    #1;
    edge_no  = cyc;
    dl_start = 1'b0;
    dl_valid = 1'b0;
    dl_end   = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic compareWrites(input string tag);
    int n;
    checkOutput({tag, "_count"}, seen.size(), expq.size());
    n = (seen.size() < expq.size()) ? seen.size() : expq.size();
    for (int i = 0; i < n; i++) begin
      checkOutput($sformatf("%s_cyc%0d", tag, i), seen[i].cyc, expq[i].cyc);
      checkOutput($sformatf("%s_addr%0d", tag, i), seen[i].a, expq[i].a);
      checkOutput($sformatf("%s_data%0d", tag, i), seen[i].d, expq[i].d);
    end
    seen.delete();
    expq.delete();
  endtask

  // Erase writes expected from entry edge ent until abandoned at edge s.
  task automatic addErase(input int unsigned ent, input logic [24:0] a0, input int unsigned s);
    int j;
    j = 0;
    for (int unsigned c = ent + 1; c < s; c += 32) begin
      expq.push_back(mk(c, a0 + 25'(j), 8'h00));
      j++;
    end
  endtask

  initial begin
    vec_t        vecs[8];
    logic [7:0]  abytes[3];
    int unsigned e, f, r, drop;
    logic        found;
    logic        pend;
    int unsigned pend_e;
    logic [24:0] pend_a;

    vecs[0] = '{5'd0,  8'h12, 25'h080000, 1'b0};
    vecs[1] = '{5'd1,  8'h34, 25'h000100, 1'b1};
    vecs[2] = '{5'd2,  8'h56, 25'h010000, 1'b0};
    vecs[3] = '{5'd3,  8'h78, 25'h100000, 1'b0};
    vecs[4] = '{5'd4,  8'h9A, 25'h000000, 1'b0};
    vecs[5] = '{5'd7,  8'hBC, 25'h000000, 1'b0};
    vecs[6] = '{5'd16, 8'hDE, 25'h000000, 1'b0};
    vecs[7] = '{5'd31, 8'hF0, 25'h000000, 1'b0};
    abytes[0] = 8'hA5;
    abytes[1] = 8'h5A;
    abytes[2] = 8'h11;

    reset_n     = 1'b0;
    dl_index    = '0;
    dl_start    = 1'b0;
    dl_end      = 1'b0;
    dl_valid    = 1'b0;
    dl_byte     = '0;
    force_erase = 1'b0;

    // Reset values.
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_wr", wr, 0);
    checkOutput("rst_addr", addr, 0);
    checkOutput("rst_dout", dout, 0);
    checkOutput("rst_downloading", downloading, 0);
    checkOutput("rst_erasing", erasing, 0);
`ifdef DL_LOADER_CHECKSUM_EN
    checkOutput("rst_sum", dl_sum, 0);
    checkOutput("rst_len", dl_len, 0);
`endif
    #2 reset_n = 1'b1;
    idle(2);

    // Table: one byte per index; index 1 leaves an erase that the next
    // dl_start abandons.
    $display("[TB] index table");
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, vecs[i].index, 1'b0, 8'h00, 1'b0, e);
      applyStimulus(1'b0, 5'd0, 1'b1, vecs[i].data, 1'b0, e);
      @(negedge clk);
      checkOutput($sformatf("vec%0d_wr", i), wr, 1);
      checkOutput($sformatf("vec%0d_addr", i), addr, vecs[i].exp_addr);
      checkOutput($sformatf("vec%0d_dout", i), dout, vecs[i].data);
      applyStimulus(1'b0, 5'd0, 1'b0, 8'h00, 1'b1, e);
      @(negedge clk);
      checkOutput($sformatf("vec%0d_erasing", i), erasing, vecs[i].exp_erase);
      checkOutput($sformatf("vec%0d_downloading", i), downloading, vecs[i].exp_erase);
      checkOutput($sformatf("vec%0d_wr_low", i), wr, 0);
      checkOutput($sformatf("vec%0d_hold_addr", i), addr, vecs[i].exp_addr);
      checkOutput($sformatf("vec%0d_hold_dout", i), dout, vecs[i].data);
    end
    idle(2);
    seen.delete();

    // Index 2, three bytes with a gap.
    $display("[TB] index 2 download");
    applyStimulus(1'b1, 5'd2, 1'b0, 8'h00, 1'b0, e);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b0, 5'd0, 1'b1, abytes[k], 1'b0, e);
      expq.push_back(mk(e, 25'h010000 + 25'(k), abytes[k]));
      if (k == 1) idle(1);
    end
    @(negedge clk);
    checkOutput("a_downloading_busy", downloading, 1);
    applyStimulus(1'b0, 5'd0, 1'b0, 8'h00, 1'b1, e);
    @(negedge clk);
    checkOutput("a_downloading_end", downloading, 0);
    idle(3);
    compareWrites("a");

    // Index 1, three bytes, then a full tail erase 0x103..0x1FF.
    $display("[TB] tail erase");
    applyStimulus(1'b1, 5'd1, 1'b0, 8'h00, 1'b0, e);
    for (int k = 0; k < 3; k++) begin
      logic [7:0] b;
      b = 8'($urandom);
      applyStimulus(1'b0, 5'd0, 1'b1, b, 1'b0, e);
      expq.push_back(mk(e, 25'h000100 + 25'(k), b));
    end
    applyStimulus(1'b0, 5'd0, 1'b0, 8'h00, 1'b1, e);
    for (int j = 0; j < 253; j++) expq.push_back(mk(e + 1 + 32*j, 25'h000103 + 25'(j), 8'h00));
    @(negedge clk);
    checkOutput("b_erasing", erasing, 1);
    drop = 0;
    for (int n = 0; n < 253*32 + 64; n++) begin
      @(negedge clk);
      if (!erasing) begin
        drop = cyc;
        break;
      end
    end
    checkOutput("b_erase_done", erasing, 0);
    checkOutput("b_drop_cycle", drop, e + 1 + 32*252);
    checkOutput("b_downloading", downloading, 0);
    idle(3);
    compareWrites("b");

    // Index 1, 256 bytes: ends aligned, no erase.
    $display("[TB] aligned end");
    applyStimulus(1'b1, 5'd1, 1'b0, 8'h00, 1'b0, e);
    for (int k = 0; k < 256; k++) begin
      applyStimulus(1'b0, 5'd0, 1'b1, 8'(k), 1'b0, e);
      expq.push_back(mk(e, 25'h000100 + 25'(k), 8'(k)));
    end
    applyStimulus(1'b0, 5'd0, 1'b0, 8'h00, 1'b1, e);
    @(negedge clk);
    checkOutput("c_downloading", downloading, 0);
    checkOutput("c_erasing", erasing, 0);
    idle(40);
    compareWrites("c");

    // Index 7 with dl_valid and dl_end together.
    $display("[TB] default base, valid with end");
    applyStimulus(1'b1, 5'd7, 1'b0, 8'h00, 1'b0, e);
    applyStimulus(1'b0, 5'd0, 1'b1, 8'h3C, 1'b1, e);
    @(negedge clk);
    checkOutput("d_wr", wr, 1);
    checkOutput("d_addr", addr, 25'h0);
    checkOutput("d_dout", dout, 8'h3C);
    checkOutput("d_downloading", downloading, 0);
`ifdef DL_LOADER_CHECKSUM_EN
    checkOutput("d_sum", dl_sum, 16'h003C);
    checkOutput("d_len", dl_len, 25'd1);
`endif
    idle(2);
    seen.delete();

    // Randomized downloads; index 1 erases get abandoned by the next start.
    $display("[TB] random downloads");
    pend = 1'b0;
    for (int it = 0; it < 8; it++) begin
      int          idx;
      int          len;
      logic        combined;
      logic [24:0] base;
      logic [24:0] wend;
      logic [15:0] sum;
      idx = int'($urandom_range(0, 7));
      if (it == 1 || it == 4) idx = 1;
      applyStimulus(1'b1, 5'(idx), 1'b0, 8'h00, 1'b0, e);
      if (pend) begin
        addErase(pend_e, pend_a, e);
        pend = 1'b0;
      end
      len      = int'($urandom_range(1, 12));
      base     = model_base(idx);
      sum      = '0;
      combined = 1'($urandom_range(0, 1));
      for (int k = 0; k < len; k++) begin
        logic [7:0] b;
        idle(int'($urandom_range(0, 2)));
        b = 8'($urandom);
        applyStimulus(1'b0, 5'd0, 1'b1, b, combined && (k == len - 1), e);
        expq.push_back(mk(e, base + 25'(k), b));
        sum = sum + 16'(b);
      end
      if (!combined) begin
        idle(int'($urandom_range(0, 2)));
        applyStimulus(1'b0, 5'd0, 1'b0, 8'h00, 1'b1, e);
      end
      wend = base + 25'(len);
      @(negedge clk);
`ifdef DL_LOADER_CHECKSUM_EN
      checkOutput($sformatf("r%0d_sum", it), dl_sum, sum);
      checkOutput($sformatf("r%0d_len", it), dl_len, 25'(len));
`endif
      if (idx == 1 && wend[7:0] != 8'h00) begin
        pend   = 1'b1;
        pend_e = e;
        pend_a = wend;
        checkOutput($sformatf("r%0d_erasing", it), erasing, 1);
      end else begin
        checkOutput($sformatf("r%0d_idle", it), downloading, 0);
      end
      idle(int'($urandom_range(0, 100)));
    end
    applyStimulus(1'b1, 5'd2, 1'b0, 8'h00, 1'b0, e);
    if (pend) addErase(pend_e, pend_a, e);
    applyStimulus(1'b0, 5'd0, 1'b0, 8'h00, 1'b1, e);
    idle(2);
    compareWrites("r");

    // Forced erase during LOAD, then reset while erasing.
    $display("[TB] forced erase and reset");
    applyStimulus(1'b1, 5'd2, 1'b0, 8'h00, 1'b0, e);
    applyStimulus(1'b0, 5'd0, 1'b1, 8'h77, 1'b0, e);
    expq.push_back(mk(e, 25'h010000, 8'h77));
    force_erase = 1'b1;
    @(posedge clk);
    #1;
    f = cyc;
    @(negedge clk);
    checkOutput("f_erasing", erasing, 1);
    applyStimulus(1'b0, 5'd0, 1'b1, 8'h99, 1'b0, e);
    idle(100);
    force_erase = 1'b0;
    idle(150);
    found = 1'b0;
    r = cyc;
    for (int n = 0; n < 64; n++) begin
      @(negedge clk);
      if (wr === 1'b1) begin
        found = 1'b1;
        r = cyc;
        break;
      end
    end
    checkOutput("f_wr_found", found, 1);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("f_rst_wr", wr, 0);
    checkOutput("f_rst_downloading", downloading, 0);
    checkOutput("f_rst_erasing", erasing, 0);
    begin
      int j;
      j = 0;
      for (int unsigned c = f + 1; c <= r; c += 32) begin
        expq.push_back(mk(c, 25'(j), 8'h00));
        j++;
      end
    end
    repeat (2) @(posedge clk);
    #3 reset_n = 1'b1;
    idle(100);
    checkOutput("f_post_wr", wr, 0);
    checkOutput("f_post_addr", addr, 0);
    checkOutput("f_post_downloading", downloading, 0);
    compareWrites("f");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
